det_seq_engine: RTL and testbench

- Sequential, parametrised determinant unit for square integer matrices of any size from 1x1 to MAX_N x MAX_N. It replaces the per-size combinational determinant instances.
- Uses fraction-free Bareiss elimination with row-swap pivoting. One element update is done per pass, through a shared multiplier and a sequential exact divider.
- Sits in the coprocessor ALU as the determinant operation and uses a start/busy/done handshake.

---
 rtl/det_pkg.sv | 22 ++
 rtl/exact_divider.sv | 70 +++++++
 rtl/det_seq_engine.sv | 214 +++++++++++++++++++++
 tb/tb_det_seq_engine.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/det_pkg.sv
// Shared definitions for the sequential Bareiss determinant engine and its divider.
package det_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PIVOT,
        S_SEARCH,
        S_SWAP,
        S_UPDATE,
        S_DIV,
        S_FINISH
    } state_t;

    localparam int DEF_IW = 48;
    localparam int PW     = 2 * DEF_IW;

    // Flat row-major element index of (r,c) in a max_n x max_n matrix.
    function automatic int idx(input int r, input int c, input int max_n);
        return r * max_n + c;
    endfunction

endpackage

// File: rtl/exact_divider.sv
// Sequential signed restoring divider; one quotient bit per cycle, PW+2 cycles go-to-done.
module exact_divider
    import det_pkg::*;
#(
    parameter int IW = DEF_IW,
    parameter int PW = det_pkg::PW
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 go,
    input  logic signed [PW-1:0] dividend,
    input  logic signed [IW-1:0] divisor,
    output logic signed [IW-1:0] quotient,
    output logic                 done
);
    localparam int CW = $clog2(PW + 1);

    logic          running;
    logic          neg;
    logic [CW-1:0] count;
    logic [PW-1:0] quo;
    logic [IW-1:0] rem;
    logic [IW-1:0] dvs;
    logic [PW-1:0] dividend_abs;
    logic [IW-1:0] divisor_abs;
    logic [IW:0]   rem_sh;
    logic [IW-1:0] rem_sub;
    logic          fit;

    assign dividend_abs = dividend[PW-1] ? -dividend : dividend;
    assign divisor_abs  = divisor[IW-1] ? -divisor : divisor;
    assign rem_sh       = {rem, quo[PW-1]};
    assign fit          = rem_sh >= {1'b0, dvs};
    // Only used when fit is set, so the true difference always fits in IW bits.
    assign rem_sub      = rem_sh[IW-1:0] - dvs;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            running  <= 1'b0;
            neg      <= 1'b0;
            count    <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            quotient <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!running) begin
                if (go) begin
                    running <= 1'b1;
                    count   <= CW'(PW);
                    quo     <= dividend_abs;
                    rem     <= '0;
                    dvs     <= divisor_abs;
                    neg     <= dividend[PW-1] ^ divisor[IW-1];
                end
            end else if (count != '0) begin
                rem   <= fit ? rem_sub : rem_sh[IW-1:0];
                quo   <= {quo[PW-2:0], fit};
                count <= count - CW'(1);
            end else begin
                running  <= 1'b0;
                done     <= 1'b1;
                quotient <= neg ? -quo[IW-1:0] : quo[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/det_seq_engine.sv
// Sequential determinant unit: fraction-free Bareiss elimination with row-swap pivoting,
// one element update per pass through a shared multiplier and the exact divider.
//
//   state    | meaning
//   IDLE     | wait for start; latch matrix and size
//   PIVOT    | test M[k][k]; start updates or search for a nonzero pivot
//   SEARCH   | scan rows below k for nonzero M[r][k]; none means det = 0
//   SWAP     | exchange rows k and r, flip sign
//   UPDATE   | two-cycle cross product through the shared multiplier
//   DIV      | wait for exact division by the previous pivot
//   FINISH   | publish signed result, overflow flag, done pulse
module det_seq_engine
    import det_pkg::*;
#(
    parameter int MAX_N = 5,
    parameter int EW    = 8,
    parameter int RW    = 8,
    parameter int IW    = DEF_IW
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [MAX_N*MAX_N*EW-1:0] A_flat,
    input  logic [2:0]                matrix_size,
    output logic                      busy,
    output logic                      done,
    output logic [RW-1:0]             number,
    output logic                      overflow_flag,
    output logic                      size_error
);
    localparam int PROD_W = 2 * IW;
    localparam int AW     = $clog2(MAX_N * MAX_N);
    localparam logic [2:0] MAX_N3 = 3'(MAX_N);
    localparam logic signed [IW-1:0] RES_MAX = IW'((64'sd1 <<< (RW - 1)) - 64'sd1);
    localparam logic signed [IW-1:0] RES_MIN = ~RES_MAX;

    state_t state;
    logic [2:0] n, k, i, j, r, last;
    logic sign_neg, zero_det, phase, div_go, div_done;
    logic accept, size_ok, prev_is_one, wr_en;
    logic signed [IW-1:0] m [MAX_N*MAX_N];
    logic signed [IW-1:0] prev, mul_a, mul_b, wr_val, m_last, det_val, div_q;
    logic signed [PROD_W-1:0] product, prod_hold, p_diff, div_dividend;

    function automatic logic [AW-1:0] ix(input logic [2:0] row, input logic [2:0] col);
        return AW'(idx(int'(row), int'(col), MAX_N));
    endfunction

    assign last        = n - 3'd1;
    assign accept      = (state == S_IDLE) && start;
    assign size_ok     = (matrix_size != 3'd0) && (matrix_size <= MAX_N3);
    assign prev_is_one = (prev == IW'(1));

    // Phase 0 forms M[i][j]*M[k][k]; phase 1 forms M[i][k]*M[k][j] on the same multiplier.
    always_comb begin
        if (phase) begin
            mul_a = m[ix(i, k)];
            mul_b = m[ix(k, j)];
        end else begin
            mul_a = m[ix(i, j)];
            mul_b = m[ix(k, k)];
        end
    end

    assign product = PROD_W'(mul_a) * PROD_W'(mul_b);
    assign p_diff  = prod_hold - product;
    assign wr_en   = ((state == S_UPDATE) && phase && prev_is_one) ||
                     ((state == S_DIV) && div_done);
    assign wr_val  = (state == S_DIV) ? div_q : p_diff[IW-1:0];
    assign m_last  = m[ix(last, last)];
    assign det_val = zero_det ? '0 : (sign_neg ? -m_last : m_last);

    exact_divider #(
        .IW(IW),
        .PW(PROD_W)
    ) u_div (
        .clock   (clock),
        .reset   (reset),
        .go      (div_go),
        .dividend(div_dividend),
        .divisor (prev),
        .quotient(div_q),
        .done    (div_done)
    );

    // Matrix storage carries no reset; contents are reloaded on every accepted start.
    always_ff @(posedge clock) begin
        for (int rr = 0; rr < MAX_N; rr++) begin
            for (int cc = 0; cc < MAX_N; cc++) begin
                if (accept) begin
                    m[AW'(idx(rr, cc, MAX_N))] <=
                        IW'(signed'(A_flat[idx(rr, cc, MAX_N)*EW +: EW]));
                end else if ((state == S_SWAP) && (3'(cc) >= k) && (3'(cc) < n)) begin
                    if (3'(rr) == k)
                        m[AW'(idx(rr, cc, MAX_N))] <= m[ix(r, 3'(cc))];
                    else if (3'(rr) == r)
                        m[AW'(idx(rr, cc, MAX_N))] <= m[ix(k, 3'(cc))];
                end else if (wr_en && (3'(rr) == i) && (3'(cc) == j)) begin
                    m[AW'(idx(rr, cc, MAX_N))] <= wr_val;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            n             <= '0;
            k             <= '0;
            i             <= '0;
            j             <= '0;
            r             <= '0;
            sign_neg      <= 1'b0;
            zero_det      <= 1'b0;
            phase         <= 1'b0;
            prev          <= IW'(1);
            prod_hold     <= '0;
            div_go        <= 1'b0;
            div_dividend  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            number        <= '0;
            overflow_flag <= 1'b0;
            size_error    <= 1'b0;
        end else begin
            done   <= 1'b0;
            div_go <= 1'b0;
            if (wr_en) begin
                phase <= 1'b0;
                state <= S_UPDATE;
                if (j != last) begin
                    j <= j + 3'd1;
                end else if (i != last) begin
                    i <= i + 3'd1;
                    j <= k + 3'd1;
                end else begin
                    prev  <= m[ix(k, k)];
                    k     <= k + 3'd1;
                    state <= ((k + 3'd1) == last) ? S_FINISH : S_PIVOT;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (!size_ok) begin
                                done          <= 1'b1;
                                number        <= '0;
                                size_error    <= 1'b1;
                                overflow_flag <= 1'b0;
                            end else begin
                                n             <= matrix_size;
                                k             <= '0;
                                sign_neg      <= 1'b0;
                                zero_det      <= 1'b0;
                                phase         <= 1'b0;
                                prev          <= IW'(1);
                                busy          <= 1'b1;
                                size_error    <= 1'b0;
                                overflow_flag <= 1'b0;
                                state <= (matrix_size == 3'd1) ? S_FINISH : S_PIVOT;
                            end
                        end
                    end
                    S_PIVOT: begin
                        if (m[ix(k, k)] != '0) begin
                            i     <= k + 3'd1;
                            j     <= k + 3'd1;
                            phase <= 1'b0;
                            state <= S_UPDATE;
                        end else begin
                            r     <= k + 3'd1;
                            state <= S_SEARCH;
                        end
                    end
                    S_SEARCH: begin
                        if (r == n) begin
                            zero_det <= 1'b1;
                            state    <= S_FINISH;
                        end else if (m[ix(r, k)] != '0) begin
                            state <= S_SWAP;
                        end else begin
                            r <= r + 3'd1;
                        end
                    end
                    S_SWAP: begin
                        sign_neg <= ~sign_neg;
                        state    <= S_PIVOT;
                    end
                    S_UPDATE: begin
                        if (!phase) begin
                            prod_hold <= product;
                            phase     <= 1'b1;
                        end else begin
                            div_dividend <= p_diff;
                            div_go       <= 1'b1;
                            state        <= S_DIV;
                        end
                    end
                    S_DIV: begin
                    end
                    S_FINISH: begin
                        number        <= det_val[RW-1:0];
                        overflow_flag <= (det_val > RES_MAX) || (det_val < RES_MIN);
                        done          <= 1'b1;
                        busy          <= 1'b0;
                        state         <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_det_seq_engine.sv
// Directed bench for det_seq_engine: hand-computed determinants, size errors, reset abort.
module tb_det_seq_engine;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [199:0] a_flat = '0;
    logic [2:0]   matrix_size = '0;
    logic         busy, done, overflow_flag, size_error;
    logic [7:0]   number;

    int checks = 0;
    int errors = 0;

    det_seq_engine #(
        .MAX_N(5),
        .EW   (8),
        .RW   (8),
        .IW   (48)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .A_flat       (a_flat),
        .matrix_size  (matrix_size),
        .busy         (busy),
        .done         (done),
        .number       (number),
        .overflow_flag(overflow_flag),
        .size_error   (size_error)
    );

    always #5 clock = ~clock;

    task automatic clear_mat();
        a_flat = '0;
    endtask

    task automatic put(input int r, input int c, input int v);
        a_flat[(r*5+c)*8 +: 8] = 8'(v);
    endtask

    task automatic kick(input int sz);
        matrix_size = 3'(sz);
        start = 1'b1;
    endtask

    task automatic wait_done(input int limit, output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < limit) begin
            @(posedge clock);
            #1;
            start = 1'b0;
            cyc++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (number !== 8'h00) begin errors++; $display("FAIL reset_number: got %h expected 00", number); end
        checks++; if (overflow_flag !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow_flag); end
        checks++; if (size_error !== 1'b0) begin errors++; $display("FAIL reset_size_error: got %b expected 0", size_error); end
    endtask

    task automatic test_2x2();
        int cyc; bit seen;
        clear_mat();
        put(0, 0, 3); put(0, 1, 1); put(1, 0, 2); put(1, 1, 4);
        kick(2);
        @(posedge clock); #1; start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL 2x2_busy_after_start: got %b expected 1", busy); end
        wait_done(200, cyc, seen);
        checks++; if (!seen) begin errors++; $display("FAIL 2x2_done_timeout: got no done expected done"); end
        checks++; if (number !== 8'h0A) begin errors++; $display("FAIL 2x2_number: got %h expected 0a", number); end
        checks++; if (overflow_flag !== 1'b0) begin errors++; $display("FAIL 2x2_ovf: got %b expected 0", overflow_flag); end
        checks++; if (size_error !== 1'b0) begin errors++; $display("FAIL 2x2_size_error: got %b expected 0", size_error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL 2x2_busy_at_done: got %b expected 0", busy); end
        @(posedge clock); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL 2x2_done_pulse_width: got %b expected 0", done); end
    endtask

    task automatic test_swap_3x3();
        int cyc; bit seen;
        clear_mat();
        put(0, 0, 0); put(0, 1, 2); put(0, 2, 1);
        put(1, 0, 1); put(1, 1, 0); put(1, 2, 3);
        put(2, 0, 4); put(2, 1, 1); put(2, 2, 0);
        kick(3);
        wait_done(500, cyc, seen);
        checks++; if (!seen) begin errors++; $display("FAIL swap3_done_timeout: got no done expected done"); end
        checks++; if (number !== 8'h19) begin errors++; $display("FAIL swap3_number: got %h expected 19", number); end
        checks++; if (overflow_flag !== 1'b0) begin errors++; $display("FAIL swap3_ovf: got %b expected 0", overflow_flag); end
    endtask

    task automatic test_5x5_diag(input int v, input logic [7:0] exp_num, input logic exp_ovf);
        int cyc; bit seen;
        clear_mat();
        for (int d = 0; d < 5; d++) put(d, d, v);
        kick(5);
        wait_done(3500, cyc, seen);
        checks++; if (!seen) begin errors++; $display("FAIL diag%0d_latency: got no done in %0d cycles expected <= 3500", v, cyc); end
        checks++; if (number !== exp_num) begin errors++; $display("FAIL diag%0d_number: got %h expected %h", v, number, exp_num); end
        checks++; if (overflow_flag !== exp_ovf) begin errors++; $display("FAIL diag%0d_ovf: got %b expected %b", v, overflow_flag, exp_ovf); end
    endtask

    task automatic test_early_exit();
        int cyc; bit seen;
        clear_mat();
        put(0, 1, 1); put(0, 2, 2); put(0, 3, 3);
        put(1, 1, 4); put(1, 2, 5); put(1, 3, 6);
        put(2, 1, 7); put(2, 2, 8); put(2, 3, 9);
        put(3, 1, 1); put(3, 2, 1); put(3, 3, 1);
        kick(4);
        wait_done(10, cyc, seen);
        checks++; if (!seen) begin errors++; $display("FAIL early_exit_latency: got no done within %0d cycles expected <= 10", cyc); end
        checks++; if (number !== 8'h00) begin errors++; $display("FAIL early_exit_number: got %h expected 00", number); end
    endtask

    task automatic test_1x1();
        int cyc; bit seen;
        clear_mat();
        put(0, 0, -7);
        put(1, 1, 5);
        kick(1);
        wait_done(20, cyc, seen);
        checks++; if (!seen) begin errors++; $display("FAIL 1x1_done_timeout: got no done expected done"); end
        checks++; if (number !== 8'hF9) begin errors++; $display("FAIL 1x1_number: got %h expected f9", number); end
        checks++; if (overflow_flag !== 1'b0) begin errors++; $display("FAIL 1x1_ovf: got %b expected 0", overflow_flag); end
    endtask

    task automatic test_size_error(input int sz);
        int cyc; bit seen;
        clear_mat();
        put(0, 0, 9);
        kick(sz);
        wait_done(5, cyc, seen);
        checks++; if (!seen || cyc != 1) begin errors++; $display("FAIL size%0d_latency: got seen=%0b cyc=%0d expected done at cycle 1", sz, seen, cyc); end
        checks++; if (number !== 8'h00) begin errors++; $display("FAIL size%0d_number: got %h expected 00", sz, number); end
        checks++; if (size_error !== 1'b1) begin errors++; $display("FAIL size%0d_size_error: got %b expected 1", sz, size_error); end
        checks++; if (overflow_flag !== 1'b0) begin errors++; $display("FAIL size%0d_ovf: got %b expected 0", sz, overflow_flag); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL size%0d_busy: got %b expected 0", sz, busy); end
    endtask

    task automatic test_reset_abort();
        int pulses;
        int stale;
        logic [7:0] got;
        clear_mat();
        for (int d = 0; d < 5; d++) put(d, d, 2);
        kick(5);
        repeat (60) begin
            @(posedge clock); #1;
            start = 1'b0;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_mid_op: got %b expected 1", busy); end
        reset = 1'b1;
        #2;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_in_reset: got busy=%b done=%b expected 0 0", busy, done); end
        @(posedge clock); #1;
        reset = 1'b0;
        stale = 0;
        repeat (150) begin
            @(posedge clock); #1;
            if (done) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL abort_stale_done: got %0d pulses expected 0", stale); end

        clear_mat();
        put(0, 0, 1); put(0, 1, 2); put(1, 0, 3); put(1, 1, 4);
        kick(2);
        pulses = 0;
        got = 8'h00;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (c == 1) begin
                matrix_size = 3'd0;
                a_flat = '0;
                start = 1'b1;
            end
            if (done) begin
                pulses++;
                got = number;
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL busy_start_pulses: got %0d expected 1", pulses); end
        checks++; if (got !== 8'hFE) begin errors++; $display("FAIL abort_new_number: got %h expected fe", got); end
        checks++; if (size_error !== 1'b0) begin errors++; $display("FAIL busy_start_size_error: got %b expected 0", size_error); end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clock); #1;
        test_2x2();
        test_swap_3x3();
        test_5x5_diag(2, 8'h20, 1'b0);
        test_5x5_diag(10, 8'hA0, 1'b1);
        test_early_exit();
        test_1x1();
        test_size_error(0);
        test_size_error(6);
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
